// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - shared widths, baud rate list and scan states for the autobaud controller
package baud_pkg;

   localparam int NUM_RATES = 13;
   localparam int PERIOD_W  = 20;
   localparam int INDEX_W   = 4;

   // Rates in Hz, slowest first; each period is derived independently from the clock
   localparam int unsigned RATE_HZ [NUM_RATES] = '{
      300, 600, 1200, 2400, 4800, 9600, 19200,
      38400, 57600, 115200, 230400, 460800, 921600
   };

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      LISTEN,
      STEP,
      LOCKED,
      FAIL
   } state_t;

endpackage

// File: rtl/baud_period_rom.sv
// rtl/baud_period_rom.sv - combinational table index to bit period (clocks per bit)
module baud_period_rom
   import baud_pkg::*;
#(
   parameter int unsigned CLOCK_SPEED = 25000000
) (
   input  logic [INDEX_W-1:0]  i_Index,
   output logic [PERIOD_W-1:0] o_Period
);

   logic [PERIOD_W-1:0] rom_w [NUM_RATES];

   // Every entry is a constant quotient, so no divider is built
   for (genvar g = 0; g < NUM_RATES; g++) begin : g_rom
      assign rom_w[g] = PERIOD_W'(CLOCK_SPEED / RATE_HZ[g]);
   end

   // Out-of-range indices fall back to the slowest rate
   always_comb begin
      o_Period = rom_w[0];
      if (32'(i_Index) < NUM_RATES) begin
         o_Period = rom_w[i_Index];
      end
   end

endmodule

// File: rtl/baud_scan_ctrl.sv
// rtl/baud_scan_ctrl.sv - autobaud scan controller; BAUD_SCAN_RELOCK_EN enables error-driven relock
module baud_scan_ctrl
   import baud_pkg::*;
#(
   parameter int unsigned CLOCK_SPEED = 25000000,
   parameter logic [7:0]  SYNC_BYTE   = 8'h55,
   parameter int unsigned MATCHES_REQ = 2,
   parameter int unsigned DWELL_BITS  = 40,
   parameter int unsigned MAX_SWEEPS  = 3,
   parameter int unsigned START_INDEX = 0
) (
   input  logic                i_Clk,
   input  logic                i_Rst_L,
   input  logic                i_Start,
   input  logic                i_Rx_DV,
   input  logic [7:0]          i_Rx_Byte,
   input  logic                i_Rx_Err,
   output logic [PERIOD_W-1:0] o_Period,
   output logic [INDEX_W-1:0]  o_Index,
   output logic                o_Period_Upd,
   output logic                o_Searching,
   output logic                o_Locked,
   output logic                o_Fail
);

   localparam logic [3:0]          MATCH_C      = 4'(MATCHES_REQ);
   localparam logic [7:0]          DWELL_C      = 8'(DWELL_BITS);
   localparam logic [3:0]          SWEEP_C      = 4'(MAX_SWEEPS);
   localparam logic [INDEX_W-1:0]  START_C      = INDEX_W'(START_INDEX);
   localparam logic [INDEX_W-1:0]  LAST_C       = INDEX_W'(NUM_RATES - 1);
   localparam logic [PERIOD_W-1:0] START_PERIOD = PERIOD_W'(CLOCK_SPEED / RATE_HZ[START_INDEX]);

   state_t              state_q, state_d;
   logic [INDEX_W-1:0]  index_q, index_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                upd_q, upd_d;
   logic [3:0]          match_q, match_d;
   logic [PERIOD_W-1:0] tick_q, tick_d;
   logic [7:0]          bit_q, bit_d;
   logic [3:0]          sweep_q, sweep_d;
`ifdef BAUD_SCAN_RELOCK_EN
   logic [2:0]          err_q, err_d;
`endif

   logic [PERIOD_W-1:0] rom_period;
   logic [INDEX_W-1:0]  next_idx;
   logic                wrap;

   baud_period_rom #(
      .CLOCK_SPEED(CLOCK_SPEED)
   ) u_rom (
      .i_Index  (index_q),
      .o_Period (rom_period)
   );

   assign next_idx = (index_q == LAST_C) ? '0 : index_q + 1'b1;
   assign wrap     = (next_idx == START_C);

   // Next-state logic: scan sequencing, bit-period timing and sync-byte matching
   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      period_d = period_q;
      upd_d    = 1'b0;
      match_d  = match_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      sweep_d  = sweep_q;
`ifdef BAUD_SCAN_RELOCK_EN
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: ;
         APPLY: begin
            period_d = rom_period;
            upd_d    = 1'b1;
            match_d  = '0;
            tick_d   = '0;
            bit_d    = '0;
`ifdef BAUD_SCAN_RELOCK_EN
            err_d    = '0;
`endif
            state_d  = LISTEN;
         end
         LISTEN: begin
            if (tick_q == period_q - 1'b1) begin
               tick_d = '0;
               bit_d  = bit_q + 1'b1;
            end else begin
               tick_d = tick_q + 1'b1;
            end
            // A framing error outranks a byte landing in the same cycle
            if (i_Rx_Err) begin
               state_d = STEP;
            end else if (i_Rx_DV) begin
               if (i_Rx_Byte == SYNC_BYTE) begin
                  match_d = match_q + 4'd1;
                  tick_d  = '0;
                  bit_d   = '0;
                  if ((match_q + 4'd1) == MATCH_C) begin
                     state_d = LOCKED;
                  end
               end else begin
                  state_d = STEP;
               end
            end else if (bit_q == DWELL_C) begin
               state_d = STEP;
            end
         end
         STEP: begin
            if (wrap) begin
               sweep_d = sweep_q + 4'd1;
            end
            // On giving up the index stays on the last rate tried, matching o_Period
            if (wrap && ((sweep_q + 4'd1) == SWEEP_C)) begin
               state_d = FAIL;
            end else begin
               index_d = next_idx;
               state_d = APPLY;
            end
         end
         LOCKED: begin
`ifdef BAUD_SCAN_RELOCK_EN
            if (i_Rx_Err) begin
               err_d = err_q + 3'd1;
               if (err_q == 3'd3) begin
                  err_d   = '0;
                  sweep_d = '0;
                  state_d = APPLY;
               end
            end else if (i_Rx_DV) begin
               err_d = '0;
            end
`endif
         end
         FAIL: ;
         default: state_d = IDLE;
      endcase
      // A start request overrides whatever else happened this cycle
      if (i_Start) begin
         state_d  = APPLY;
         index_d  = START_C;
         sweep_d  = '0;
         period_d = period_q;
         upd_d    = 1'b0;
      end
   end

   // State and datapath registers
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q  <= IDLE;
         index_q  <= START_C;
         period_q <= START_PERIOD;
         upd_q    <= 1'b0;
         match_q  <= '0;
         tick_q   <= '0;
         bit_q    <= '0;
         sweep_q  <= '0;
`ifdef BAUD_SCAN_RELOCK_EN
         err_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         period_q <= period_d;
         upd_q    <= upd_d;
         match_q  <= match_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         sweep_q  <= sweep_d;
`ifdef BAUD_SCAN_RELOCK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign o_Period     = period_q;
   assign o_Index      = index_q;
   assign o_Period_Upd = upd_q;
   assign o_Searching  = (state_q == APPLY) || (state_q == LISTEN);
   assign o_Locked     = (state_q == LOCKED);
   assign o_Fail       = (state_q == FAIL);

endmodule

// File: tb/tb_baud_scan_ctrl.sv
// tb/tb_baud_scan_ctrl.sv - directed self-checking bench for baud_scan_ctrl
module tb_baud_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, dv, err;
   logic [7:0]  rx_byte;
   logic [19:0] period;
   logic [3:0]  index;
   logic        upd, searching, locked, fail;

   logic        f_start, f_dv, f_err;
   logic [7:0]  f_byte;
   logic [19:0] f_period;
   logic [3:0]  f_index;
   logic        f_upd, f_searching, f_locked, f_fail;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc;

   always #5 clk = ~clk;

   baud_scan_ctrl u_dut (
      .i_Clk        (clk),
      .i_Rst_L      (rst_n),
      .i_Start      (start),
      .i_Rx_DV      (dv),
      .i_Rx_Byte    (rx_byte),
      .i_Rx_Err     (err),
      .o_Period     (period),
      .o_Index      (index),
      .o_Period_Upd (upd),
      .o_Searching  (searching),
      .o_Locked     (locked),
      .o_Fail       (fail)
   );

   baud_scan_ctrl #(
      .CLOCK_SPEED (1000000),
      .DWELL_BITS  (1),
      .MAX_SWEEPS  (2),
      .START_INDEX (0)
   ) u_fast (
      .i_Clk        (clk),
      .i_Rst_L      (rst_n),
      .i_Start      (f_start),
      .i_Rx_DV      (f_dv),
      .i_Rx_Byte    (f_byte),
      .i_Rx_Err     (f_err),
      .o_Period     (f_period),
      .o_Index      (f_index),
      .o_Period_Upd (f_upd),
      .o_Searching  (f_searching),
      .o_Locked     (f_locked),
      .o_Fail       (f_fail)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the next o_Period_Upd pulse; returns negedges elapsed
   task automatic wait_upd(input logic use_fast, output int c);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (((use_fast ? f_upd : upd) !== 1'b1) && c < 20000);
      chk("upd_seen", 32'(c < 20000), 32'd1);
   endtask

   task automatic send(input logic [7:0] b, input logic d, input logic e);
      rx_byte = b;
      dv      = d;
      err     = e;
      @(negedge clk);
      dv  = 1'b0;
      err = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; dv = 1'b0; err = 1'b0; rx_byte = 8'h00;
      f_start = 1'b0; f_dv = 1'b0; f_err = 1'b0; f_byte = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst_index", 32'(index), 32'd0);
      chk("rst_period", 32'(period), 32'd83333);
      chk("rst_upd", 32'(upd), 32'd0);
      chk("rst_search", 32'(searching), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_fail", 32'(fail), 32'd0);

      pulse_start();
      chk("apply_search", 32'(searching), 32'd1);
      wait_upd(1'b0, cyc);
      chk("start_upd_lat", 32'(cyc), 32'd1);
      chk("start_period", 32'(period), 32'd83333);
      chk("start_index", 32'(index), 32'd0);
      chk("start_search", 32'(searching), 32'd1);

      for (int k = 0; k < 5; k++) begin
         send(8'hA3, 1'b1, 1'b0);
         wait_upd(1'b0, cyc);
      end
      chk("idx5_index", 32'(index), 32'd5);
      chk("idx5_period", 32'(period), 32'd2604);

      send(8'h55, 1'b1, 1'b0);
      chk("idx5_one_match", 32'(searching), 32'd1);
      send(8'hA3, 1'b1, 1'b0);
      chk("mismatch_step", 32'(searching), 32'd0);
      wait_upd(1'b0, cyc);
      chk("idx6_index", 32'(index), 32'd6);
      chk("idx6_period", 32'(period), 32'd1302);
      send(8'h55, 1'b1, 1'b0);
      chk("match_restart", 32'(locked), 32'd0);

      send(8'h55, 1'b1, 1'b1);
      chk("err_dv_nolock", 32'(locked), 32'd0);
      chk("err_dv_step", 32'(searching), 32'd0);
      wait_upd(1'b0, cyc);
      chk("idx7_period", 32'(period), 32'd651);

      for (int k = 0; k < 2; k++) begin
         send(8'hA3, 1'b1, 1'b0);
         wait_upd(1'b0, cyc);
      end
      chk("idx9_period", 32'(period), 32'd217);
      send(8'h55, 1'b1, 1'b0);
      chk("first_sync", 32'(locked), 32'd0);
      send(8'h55, 1'b1, 1'b0);
      chk("lock_flag", 32'(locked), 32'd1);
      chk("lock_search", 32'(searching), 32'd0);
      chk("lock_period", 32'(period), 32'd217);
      chk("lock_index", 32'(index), 32'd9);

`ifdef BAUD_SCAN_RELOCK_EN
      for (int k = 0; k < 3; k++) send(8'h00, 1'b0, 1'b1);
      chk("relock_3err", 32'(locked), 32'd1);
      send(8'h00, 1'b0, 1'b1);
      chk("relock_drop", 32'(locked), 32'd0);
      wait_upd(1'b0, cyc);
      chk("relock_upd_lat", 32'(cyc), 32'd1);
      chk("relock_period", 32'(period), 32'd217);
      chk("relock_index", 32'(index), 32'd9);
`else
      for (int k = 0; k < 4; k++) send(8'h00, 1'b0, 1'b1);
      chk("sticky_err", 32'(locked), 32'd1);
      send(8'hA3, 1'b1, 1'b0);
      chk("sticky_byte", 32'(locked), 32'd1);
      chk("sticky_period", 32'(period), 32'd217);
      chk("sticky_upd", 32'(upd), 32'd0);
`endif

      pulse_start();
      chk("start_clr_lock", 32'(locked), 32'd0);
      wait_upd(1'b0, cyc);
      chk("restart_index", 32'(index), 32'd0);

      for (int k = 0; k < 11; k++) begin
         send(8'hA3, 1'b1, 1'b0);
         wait_upd(1'b0, cyc);
      end
      chk("idx11_period", 32'(period), 32'd54);
      repeat (40 * 54) @(negedge clk);
      pulse_start();
      chk("start_dwell_idx", 32'(index), 32'd0);
      chk("start_dwell_srch", 32'(searching), 32'd1);
      wait_upd(1'b0, cyc);
      chk("start_dwell_per", 32'(period), 32'd83333);

      for (int k = 0; k < 11; k++) begin
         send(8'hA3, 1'b1, 1'b0);
         wait_upd(1'b0, cyc);
      end
      wait_upd(1'b0, cyc);
      chk("dwell11_cycles", 32'(cyc), 32'd2163);
      chk("dwell11_index", 32'(index), 32'd12);
      chk("dwell11_period", 32'(period), 32'd27);
      wait_upd(1'b0, cyc);
      chk("dwell12_cycles", 32'(cyc), 32'd1083);
      chk("wrap_index", 32'(index), 32'd0);
      chk("wrap_period", 32'(period), 32'd83333);

      f_start = 1'b1;
      @(negedge clk);
      f_start = 1'b0;
      wait_upd(1'b1, cyc);
      chk("f_start_period", 32'(f_period), 32'd3333);
      wait_upd(1'b1, cyc);
      chk("f_dwell_cycles", 32'(cyc), 32'd3336);
      chk("f_idx1_period", 32'(f_period), 32'd1666);
      for (int k = 0; k < 12; k++) wait_upd(1'b1, cyc);
      chk("f_wrap_index", 32'(f_index), 32'd0);
      chk("f_wrap_period", 32'(f_period), 32'd3333);
      chk("f_wrap_nofail", 32'(f_fail), 32'd0);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (f_fail !== 1'b1 && cyc < 20000);
      chk("f_fail_cycles", 32'(cyc), 32'd6708);
      chk("f_fail_period", 32'(f_period), 32'd1);
      chk("f_fail_search", 32'(f_searching), 32'd0);
      f_start = 1'b1;
      @(negedge clk);
      f_start = 1'b0;
      chk("f_start_clr_fail", 32'(f_fail), 32'd0);
      chk("f_restart_index", 32'(f_index), 32'd0);

      send(8'hA3, 1'b1, 1'b0);
      wait_upd(1'b0, cyc);
      chk("pre_rst_period", 32'(period), 32'd41666);
      #2 rst_n = 1'b0;
      #1;
      chk("async_index", 32'(index), 32'd0);
      chk("async_period", 32'(period), 32'd83333);
      chk("async_upd", 32'(upd), 32'd0);
      chk("async_search", 32'(searching), 32'd0);
      chk("async_locked", 32'(locked), 32'd0);
      chk("async_fail", 32'(fail), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_upd", 32'(upd), 32'd0);
      chk("post_rst_idle", 32'(searching), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
